// File: rtl/c7bbiu_arb.sv
// c7bbiu_arb: round-robin arbiter that lets the IFU and the LSU share one memory port.
// A grant is held until the memory accepts it. The owner of each accepted transaction is
// queued in an in-order ID FIFO, so every memory response goes back to the requester that
// issued it.
module c7bbiu_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OUTST  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ifu_req,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_ack,
  output logic              ifu_data_valid,
  input  logic              lsu_req,
  input  logic              lsu_wr,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_ack,
  output logic              lsu_data_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_unexp_rsp
);

  localparam int PW = $clog2(OUTST);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTST);

  // Owner encoding used in the ID FIFO and the owner register
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               pref_lsu_q, pref_lsu_d;   // 1: LSU wins the next tie
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OUTST-1:0]   fifo_q, fifo_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               err_q, err_d;

  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               head_owner;
  logic               win_lsu;

  // Grant FSM. It grants in IDLE only while the registered count leaves room, holds the
  // registered request in REQ, and pushes the owner when the memory acks.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    pref_lsu_d  = pref_lsu_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    push        = 1'b0;
    win_lsu     = lsu_req && (!ifu_req || pref_lsu_q);
    case (state_q)
      ST_IDLE: begin
        if ((ifu_req || lsu_req) && (count_q < FULL_CNT)) begin
          owner_d     = win_lsu ? OWN_LSU : OWN_IFU;
          pref_lsu_d  = !win_lsu;
          mem_req_d   = 1'b1;
          // An IFU transaction is always a read
          mem_wr_d    = win_lsu && lsu_wr;
          mem_addr_d  = win_lsu ? lsu_addr : ifu_addr;
          mem_wdata_d = win_lsu ? lsu_wdata : mem_wdata_q;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          push      = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ID FIFO bookkeeping. A response that arrives while the FIFO is empty is dropped and
  // flagged; a same-cycle push is not visible to that pop.
  always_comb begin
    fifo_empty = (count_q == '0);
    pop        = mem_rdata_valid && !fifo_empty;
    head_owner = fifo_q[rd_ptr_q];
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    err_d      = err_q || (mem_rdata_valid && fifo_empty);
  end

  // Each FIFO entry loads the current owner when the write pointer selects it on a push
  generate
    for (genvar gi = 0; gi < OUTST; gi++) begin : g_fifo
      assign fifo_d[gi] = (push && (wr_ptr_q == PW'(gi))) ? owner_q : fifo_q[gi];
    end
  endgenerate

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IFU;
      pref_lsu_q  <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      pref_lsu_q  <= pref_lsu_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_q      <= fifo_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  // The acks and response strobes are combinational and are forced low while in reset
  assign ifu_ack        = resetn && push && (owner_q == OWN_IFU);
  assign lsu_ack        = resetn && push && (owner_q == OWN_LSU);
  assign ifu_data_valid = resetn && pop && (head_owner == OWN_IFU);
  assign lsu_data_valid = resetn && pop && (head_owner == OWN_LSU);
  assign rdata          = mem_rdata;
  assign mem_req        = mem_req_q;
  assign mem_wr         = mem_wr_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign err_unexp_rsp  = err_q;

endmodule

// File: tb/tb_c7bbiu_arb.sv
// Testbench for c7bbiu_arb: directed scenarios followed by a randomized run that is checked
// against a transaction-level model (an owner queue plus a single pending grant).
module tb_c7bbiu_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OUTST = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          ifu_req, lsu_req, lsu_wr;
  logic [AW-1:0] ifu_addr, lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic          ifu_ack, lsu_ack, ifu_data_valid, lsu_data_valid;
  logic [DW-1:0] rdata;
  logic          mem_req, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack, mem_rdata_valid;
  logic [DW-1:0] mem_rdata;
  logic          err_unexp_rsp;
  logic [4:0]    flags;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  assign flags = {ifu_ack, lsu_ack, ifu_data_valid, lsu_data_valid, mem_req};

  c7bbiu_arb #(.ADDR_W(AW), .DATA_W(DW), .OUTST(OUTST)) dut (
    .clk(clk), .resetn(resetn),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ack(ifu_ack), .ifu_data_valid(ifu_data_valid),
    .lsu_req(lsu_req), .lsu_wr(lsu_wr), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_ack(lsu_ack), .lsu_data_valid(lsu_data_valid), .rdata(rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .err_unexp_rsp(err_unexp_rsp)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_inputs;
    ifu_req = 1'b0; ifu_addr = '0;
    lsu_req = 1'b0; lsu_wr = 1'b0; lsu_addr = '0; lsu_wdata = '0;
    mem_ack = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
  endtask

  task automatic apply_reset;
    resetn = 1'b0;
    idle_inputs();
    next_cycle();
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    idle_inputs();
    ifu_req = 1'b1; lsu_req = 1'b1; mem_ack = 1'b1; mem_rdata_valid = 1'b1;
    next_cycle();
    next_cycle();
    settle();
    checks++; if (flags !== 5'b00000) $display("FAIL reset_flags got=%b exp=%b", flags, 5'b00000); else passes++;
    checks++; if ({mem_wr, mem_addr, mem_wdata} !== '0) $display("FAIL reset_mem got wr=%b addr=%h wdata=%h exp=0", mem_wr, mem_addr, mem_wdata); else passes++;
    checks++; if (err_unexp_rsp !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_unexp_rsp); else passes++;
    $display("reset: flags=%b", flags);
    idle_inputs();
    resetn = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_ifu;
    ifu_req = 1'b1; ifu_addr = 32'h1C00_0000;
    settle();
    checks++; if (flags !== 5'b00000) $display("FAIL single_req got=%b exp=%b", flags, 5'b00000); else passes++;
    next_cycle(); settle();
    checks++; if (flags !== 5'b00001) $display("FAIL single_memreq got=%b exp=%b", flags, 5'b00001); else passes++;
    checks++; if ({mem_wr, mem_addr} !== {1'b0, 32'h1C00_0000}) $display("FAIL single_addr got wr=%b addr=%h exp wr=0 addr=1c000000", mem_wr, mem_addr); else passes++;
    next_cycle(); mem_ack = 1'b1; settle();
    checks++; if (flags !== 5'b10001) $display("FAIL single_ack got=%b exp=%b", flags, 5'b10001); else passes++;
    next_cycle(); mem_ack = 1'b0; ifu_req = 1'b0; settle();
    checks++; if (flags !== 5'b00000) $display("FAIL single_drop got=%b exp=%b", flags, 5'b00000); else passes++;
    next_cycle();
    next_cycle(); mem_rdata_valid = 1'b1; mem_rdata = 32'h0280_0000; settle();
    checks++; if (flags !== 5'b00100) $display("FAIL single_rsp got=%b exp=%b", flags, 5'b00100); else passes++;
    checks++; if (rdata !== 32'h0280_0000) $display("FAIL single_rdata got=%h exp=02800000", rdata); else passes++;
    $display("single_ifu: addr=1c000000 rdata=%h", rdata);
    next_cycle(); mem_rdata_valid = 1'b0; settle();
    checks++; if (err_unexp_rsp !== 1'b0) $display("FAIL single_err got=%b exp=0", err_unexp_rsp); else passes++;
  endtask

  task automatic test_round_robin;
    logic e;
    logic [AW-1:0] ea;
    apply_reset();
    ifu_req = 1'b1; lsu_req = 1'b1; lsu_wr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = k[0];
      ifu_addr = 32'h1000 + k; lsu_addr = 32'h2000 + k; mem_ack = 1'b0;
      settle();
      checks++; if (flags !== 5'b00000) $display("FAIL rr_idle%0d got=%b exp=%b", k, flags, 5'b00000); else passes++;
      next_cycle(); mem_ack = 1'b1; settle();
      ea = e ? (32'h2000 + k) : (32'h1000 + k);
      checks++; if (flags !== {~e, e, 3'b001}) $display("FAIL rr_ack%0d got=%b exp=%b", k, flags, {~e, e, 3'b001}); else passes++;
      checks++; if (mem_addr !== ea) $display("FAIL rr_addr%0d got=%h exp=%h", k, mem_addr, ea); else passes++;
      $display("rr grant %0d: owner=%s addr=%h", k, e ? "lsu" : "ifu", mem_addr);
      next_cycle();
    end
    ifu_req = 1'b0; lsu_req = 1'b0; mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = k[0];
      mem_rdata_valid = 1'b1; mem_rdata = 32'hA000 + k;
      settle();
      checks++; if (flags !== {2'b00, ~e, e, 1'b0}) $display("FAIL rr_rsp%0d got=%b exp=%b", k, flags, {2'b00, ~e, e, 1'b0}); else passes++;
      $display("rr response %0d: to=%s rdata=%h", k, e ? "lsu" : "ifu", rdata);
      next_cycle();
    end
    mem_rdata_valid = 1'b0;
  endtask

  task automatic test_lsu_write;
    lsu_req = 1'b1; lsu_wr = 1'b1; lsu_addr = 32'h1C00_1000; lsu_wdata = 32'hDEAD_BEEF;
    settle();
    checks++; if (flags !== 5'b00000) $display("FAIL wr_req got=%b exp=%b", flags, 5'b00000); else passes++;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      mem_ack = (c == 2);
      settle();
      checks++; if (flags !== ((c == 2) ? 5'b01001 : 5'b00001)) $display("FAIL wr_hold%0d got=%b exp=%b", c, flags, (c == 2) ? 5'b01001 : 5'b00001); else passes++;
      checks++; if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'h1C00_1000, 32'hDEAD_BEEF}) $display("FAIL wr_fields%0d got wr=%b addr=%h wdata=%h exp wr=1 addr=1c001000 wdata=deadbeef", c, mem_wr, mem_addr, mem_wdata); else passes++;
    end
    next_cycle(); mem_ack = 1'b0; lsu_req = 1'b0; lsu_wr = 1'b0; settle();
    checks++; if (flags !== 5'b00000) $display("FAIL wr_drop got=%b exp=%b", flags, 5'b00000); else passes++;
    next_cycle(); mem_rdata_valid = 1'b1; mem_rdata = 32'h1234_5678; settle();
    checks++; if (flags !== 5'b00010) $display("FAIL wr_rsp got=%b exp=%b", flags, 5'b00010); else passes++;
    $display("lsu_write: addr=1c001000 wdata=deadbeef completed");
    next_cycle(); mem_rdata_valid = 1'b0;
  endtask

  task automatic test_full;
    ifu_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ifu_addr = 32'h3000 + k; mem_ack = 1'b0;
      settle();
      checks++; if (flags !== 5'b00000) $display("FAIL full_idle%0d got=%b exp=%b", k, flags, 5'b00000); else passes++;
      next_cycle(); mem_ack = 1'b1; settle();
      checks++; if (flags !== 5'b10001) $display("FAIL full_ack%0d got=%b exp=%b", k, flags, 5'b10001); else passes++;
      next_cycle();
    end
    mem_ack = 1'b0;
    for (int j = 0; j < 3; j++) begin
      settle();
      checks++; if (flags !== 5'b00000) $display("FAIL full_block%0d got=%b exp=%b", j, flags, 5'b00000); else passes++;
      next_cycle();
    end
    mem_rdata_valid = 1'b1; mem_rdata = 32'h0000_3000; settle();
    checks++; if (flags !== 5'b00100) $display("FAIL full_pop got=%b exp=%b", flags, 5'b00100); else passes++;
    next_cycle(); mem_rdata_valid = 1'b0; settle();
    checks++; if (flags !== 5'b00000) $display("FAIL full_grant got=%b exp=%b", flags, 5'b00000); else passes++;
    next_cycle(); mem_ack = 1'b1; settle();
    checks++; if (flags !== 5'b10001) $display("FAIL full_resume got=%b exp=%b", flags, 5'b10001); else passes++;
    checks++; if (mem_addr !== 32'h3003) $display("FAIL full_addr got=%h exp=00003003", mem_addr); else passes++;
    $display("full: fifth request granted after one response, addr=%h", mem_addr);
    next_cycle(); mem_ack = 1'b0; ifu_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rdata_valid = 1'b1; settle();
      checks++; if (flags !== 5'b00100) $display("FAIL full_drain%0d got=%b exp=%b", k, flags, 5'b00100); else passes++;
      next_cycle();
    end
    mem_rdata_valid = 1'b0;
  endtask

  task automatic test_push_pop;
    lsu_req = 1'b1; lsu_wr = 1'b0; lsu_addr = 32'h4000; settle();
    next_cycle(); mem_ack = 1'b1; settle();
    checks++; if (flags !== 5'b01001) $display("FAIL pp_lsu_ack got=%b exp=%b", flags, 5'b01001); else passes++;
    next_cycle(); mem_ack = 1'b0; lsu_req = 1'b0; ifu_req = 1'b1; ifu_addr = 32'h5000; settle();
    next_cycle(); mem_ack = 1'b1; settle();
    checks++; if (flags !== 5'b10001) $display("FAIL pp_ifu_ack got=%b exp=%b", flags, 5'b10001); else passes++;
    next_cycle(); mem_ack = 1'b0; ifu_addr = 32'h5004; settle();
    next_cycle(); mem_ack = 1'b1; mem_rdata_valid = 1'b1; mem_rdata = 32'hBBBB_0000; settle();
    checks++; if (flags !== 5'b10011) $display("FAIL pp_same_cycle got=%b exp=%b", flags, 5'b10011); else passes++;
    $display("push_pop: ack and response together, head routed to lsu");
    next_cycle(); mem_ack = 1'b0; mem_rdata_valid = 1'b0; ifu_req = 1'b0; settle();
    checks++; if (err_unexp_rsp !== 1'b0) $display("FAIL pp_err got=%b exp=0", err_unexp_rsp); else passes++;
    for (int k = 0; k < 2; k++) begin
      next_cycle(); mem_rdata_valid = 1'b1; settle();
      checks++; if (flags !== 5'b00100) $display("FAIL pp_drain%0d got=%b exp=%b", k, flags, 5'b00100); else passes++;
    end
    next_cycle(); mem_rdata_valid = 1'b0; settle();
    checks++; if (err_unexp_rsp !== 1'b0) $display("FAIL pp_err_end got=%b exp=0", err_unexp_rsp); else passes++;
  endtask

  task automatic test_unexpected;
    next_cycle(); mem_rdata_valid = 1'b1; mem_rdata = 32'hEEEE_EEEE; settle();
    checks++; if (flags !== 5'b00000) $display("FAIL unexp_route got=%b exp=%b", flags, 5'b00000); else passes++;
    next_cycle(); mem_rdata_valid = 1'b0; settle();
    checks++; if (err_unexp_rsp !== 1'b1) $display("FAIL unexp_set got=%b exp=1", err_unexp_rsp); else passes++;
    next_cycle(); settle();
    checks++; if (err_unexp_rsp !== 1'b1) $display("FAIL unexp_sticky got=%b exp=1", err_unexp_rsp); else passes++;
    apply_reset(); settle();
    checks++; if (err_unexp_rsp !== 1'b0) $display("FAIL unexp_clear got=%b exp=0", err_unexp_rsp); else passes++;
    // Empty FIFO: a response in the same cycle as the ack cannot see the new entry
    ifu_req = 1'b1; ifu_addr = 32'h6000; settle();
    next_cycle(); mem_ack = 1'b1; mem_rdata_valid = 1'b1; settle();
    checks++; if (flags !== 5'b10001) $display("FAIL unexp_same got=%b exp=%b", flags, 5'b10001); else passes++;
    next_cycle(); mem_ack = 1'b0; mem_rdata_valid = 1'b0; ifu_req = 1'b0; settle();
    checks++; if (err_unexp_rsp !== 1'b1) $display("FAIL unexp_same_err got=%b exp=1", err_unexp_rsp); else passes++;
    next_cycle(); mem_rdata_valid = 1'b1; settle();
    checks++; if (flags !== 5'b00100) $display("FAIL unexp_after got=%b exp=%b", flags, 5'b00100); else passes++;
    $display("unexpected: err=%b", err_unexp_rsp);
    next_cycle(); mem_rdata_valid = 1'b0;
  endtask

  task automatic test_random;
    bit            busy, b_own, b_wr, pref_lsu, err_exp, win_lsu;
    bit            e_iack, e_lack, e_idv, e_ldv;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    bit            q[$];
    int            qs;
    int            ntx;
    apply_reset();
    busy = 0; b_own = 0; b_wr = 0; pref_lsu = 0; err_exp = 0; ntx = 0;
    b_addr = '0; b_wdata = '0;
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!ifu_req && $urandom_range(2) == 0) begin
        ifu_req = 1'b1; ifu_addr = $urandom;
      end
      if (!lsu_req && $urandom_range(2) == 0) begin
        lsu_req = 1'b1; lsu_wr = 1'($urandom_range(1)); lsu_addr = $urandom; lsu_wdata = $urandom;
      end
      mem_ack = busy && ($urandom_range(1) == 1);
      mem_rdata_valid = (q.size() > 0) && ($urandom_range(2) == 0);
      mem_rdata = $urandom;
      qs = q.size();
      e_iack = busy && mem_ack && !b_own;
      e_lack = busy && mem_ack && b_own;
      e_idv = 1'b0; e_ldv = 1'b0;
      if (mem_rdata_valid && qs > 0) begin
        e_idv = !q[0]; e_ldv = q[0];
      end
      settle();
      checks++; if (flags !== {e_iack, e_lack, e_idv, e_ldv, busy}) $display("FAIL rnd_flags c%0d got=%b exp=%b", cyc, flags, {e_iack, e_lack, e_idv, e_ldv, busy}); else passes++;
      if (busy) begin
        checks++; if ({mem_wr, mem_addr} !== {b_wr, b_addr}) $display("FAIL rnd_addr c%0d got wr=%b addr=%h exp wr=%b addr=%h", cyc, mem_wr, mem_addr, b_wr, b_addr); else passes++;
        if (b_own) begin
          checks++; if (mem_wdata !== b_wdata) $display("FAIL rnd_wdata c%0d got=%h exp=%h", cyc, mem_wdata, b_wdata); else passes++;
        end
      end
      checks++; if ({rdata, err_unexp_rsp} !== {mem_rdata, err_exp}) $display("FAIL rnd_rsp c%0d got rdata=%h err=%b exp rdata=%h err=%b", cyc, rdata, err_unexp_rsp, mem_rdata, err_exp); else passes++;
      // Advance the model: responses retire the oldest owner, an ack queues the granted owner
      if (mem_rdata_valid) begin
        if (qs > 0) void'(q.pop_front());
        else err_exp = 1'b1;
      end
      if (busy && mem_ack) begin
        q.push_back(b_own);
        busy = 1'b0;
        ntx++;
        $display("rnd txn %0d: owner=%s wr=%b addr=%h", ntx, b_own ? "lsu" : "ifu", b_wr, b_addr);
      end else if (!busy && (ifu_req || lsu_req) && qs < OUTST) begin
        win_lsu = lsu_req && (!ifu_req || pref_lsu);
        busy = 1'b1;
        b_own = win_lsu;
        pref_lsu = !win_lsu;
        b_addr = win_lsu ? lsu_addr : ifu_addr;
        b_wr = win_lsu && lsu_wr;
        b_wdata = lsu_wdata;
      end
      next_cycle();
      if (e_iack) ifu_req = 1'b0;
      if (e_lack) begin
        lsu_req = 1'b0; lsu_wr = 1'b0;
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_ifu();
    test_round_robin();
    test_lsu_write();
    test_full();
    test_push_pop();
    test_unexpected();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
